// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the half-precision add/sub sequencer:
// constants, flag indices, FSM states and the operand unpack helper.
package fp16_pkg;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [15:0] POS_INF  = 16'h7C00;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_UF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_MAG   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [10:0] mant;
    logic        is_nan;
    logic        is_snan;
    logic        is_inf;
    logic        is_zero;
  } fp16_unpacked_t;

  // Subnormals are presented with exponent 1 and hidden bit 0 so both
  // operands share one alignment rule; flip applies the subtract sign.
  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] v, input logic flip);
    fp16_unpacked_t u;
    u.sign    = v[15] ^ flip;
    u.exp     = (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
    u.mant    = {(v[14:10] != 5'd0), v[9:0]};
    u.is_nan  = (v[14:10] == 5'(EXP_MAX)) && (v[9:0] != 10'd0);
    u.is_snan = u.is_nan && !v[9];
    u.is_inf  = (v[14:10] == 5'(EXP_MAX)) && (v[9:0] == 10'd0);
    u.is_zero = (v[14:0] == 15'd0);
    return u;
  endfunction

endpackage

// File: rtl/half_lzc_shift.sv
// Normalizes a 15-bit magnitude so its MSB lands on bit 13, limiting the
// left shift so the exponent never drops below 1 (subnormal floor).
module half_lzc_shift (
  input  logic [14:0] val_i,
  input  logic [5:0]  exp_i,
  output logic [13:0] val_o,
  output logic [5:0]  exp_o
);

  logic [3:0] lz;
  logic [3:0] want;
  logic [5:0] room;
  logic [3:0] shamt;

  always_comb begin
    lz = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (val_i[i]) lz = 4'(14 - i);
    end
    want  = (lz == 4'd0) ? 4'd0 : lz - 4'd1;
    room  = exp_i - 6'd1;
    shamt = (room > {2'b00, want}) ? want : room[3:0];
    val_o = 14'(val_i << shamt);
    exp_o = exp_i - {2'b00, shamt};
  end

endmodule

// File: rtl/half_addsub_seq.sv
// Multi-cycle binary16 add/sub: one shared datapath stepped through
// align, magnitude add/sub, normalize and round/pack, result held until taken.
module half_addsub_seq
  import fp16_pkg::*;
#(
  parameter bit FAST_SPECIAL = 1'b1,
  parameter bit FTZ          = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_A,
  input  logic [15:0] IN_B,
  input  logic        IN_OP,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic [4:0]  FLAGS,
  output logic        BUSY,
  output state_e      DBG_STATE
);

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both high; ready never depends on valid, and a held valid keeps its data.

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic [4:0]  exp_q, exp_d;
  logic [13:0] big_q, big_d, small_q, small_d;
  logic        sub_q, sub_d;
  logic [14:0] sum_q, sum_d;
  logic [13:0] nm_q, nm_d;
  logic [5:0]  nexp_q, nexp_d;
  logic [15:0] q_q, q_d;
  logic [4:0]  flags_q, flags_d;

  fp16_unpacked_t ua, ub;
  logic [15:0] sp_a, sp_b;
  logic        sp_op, sp_hit;
  logic [15:0] sp_q;
  logic [4:0]  sp_flags;

  // Special-operand decode looks at the live inputs while idle (fast bypass)
  // and at the captured operands once an operation is in flight.
  always_comb begin
    sp_a     = (state_q == S_IDLE) ? IN_A  : a_q;
    sp_b     = (state_q == S_IDLE) ? IN_B  : b_q;
    sp_op    = (state_q == S_IDLE) ? IN_OP : op_q;
    ua       = fp16_unpack(sp_a, 1'b0);
    ub       = fp16_unpack(sp_b, sp_op);
    sp_hit   = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | ua.is_zero | ub.is_zero;
    sp_q     = 16'h0000;
    sp_flags = 5'b00000;
    if (ua.is_nan || ub.is_nan) begin
      sp_q              = QNAN;
      sp_flags[FLAG_NV] = ua.is_snan | ub.is_snan;
    end else if (ua.is_inf && ub.is_inf) begin
      if (ua.sign != ub.sign) begin
        sp_q              = QNAN;
        sp_flags[FLAG_NV] = 1'b1;
      end else begin
        sp_q = POS_INF | {ua.sign, 15'd0};
      end
    end else if (ua.is_inf) begin
      sp_q = POS_INF | {ua.sign, 15'd0};
    end else if (ub.is_inf) begin
      sp_q = POS_INF | {ub.sign, 15'd0};
    end else if (ua.is_zero && ub.is_zero) begin
      sp_q = {ua.sign & ub.sign, 15'd0};
    end else if (ua.is_zero) begin
      sp_q = {ub.sign, sp_b[14:0]};
    end else begin
      sp_q = {ua.sign, sp_a[14:0]};
    end
  end

  logic        a_big;
  logic        big_sign;
  logic [4:0]  big_exp, sml_exp, diff;
  logic [10:0] big_mant, sml_mant;
  logic [13:0] sfield, shifted, lost, aligned;

  always_comb begin
    a_big    = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    big_sign = a_big ? ua.sign : ub.sign;
    big_exp  = a_big ? ua.exp  : ub.exp;
    big_mant = a_big ? ua.mant : ub.mant;
    sml_exp  = a_big ? ub.exp  : ua.exp;
    sml_mant = a_big ? ub.mant : ua.mant;
    diff     = big_exp - sml_exp;
    sfield   = {sml_mant, 3'b000};
    shifted  = sfield >> diff;
    lost     = sfield & ~(14'h3FFF << diff);
    if (diff >= 5'd14) aligned = {13'd0, |sml_mant};
    else               aligned = {shifted[13:1], shifted[0] | (|lost)};
  end

  logic [13:0] lz_val;
  logic [5:0]  lz_exp;

  half_lzc_shift u_lzc (
    .val_i (sum_q),
    .exp_i ({1'b0, exp_q}),
    .val_o (lz_val),
    .exp_o (lz_exp)
  );

  logic [10:0] rm, rmant;
  logic        g, r, s, rnd_up, nx, tiny;
  logic [11:0] rsum;
  logic [5:0]  rexp;
  logic [15:0] rq;
  logic [4:0]  rflags;

  always_comb begin
    rm     = nm_q[13:3];
    g      = nm_q[2];
    r      = nm_q[1];
    s      = nm_q[0];
    rnd_up = g & (r | s | rm[0]);
    rsum   = {1'b0, rm} + {11'd0, rnd_up};
    rmant  = rsum[11] ? rsum[11:1] : rsum[10:0];
    rexp   = rsum[11] ? nexp_q + 6'd1 : nexp_q;
    nx     = g | r | s;
    tiny   = ~nm_q[13];
    rq     = {sign_q, (rmant[10] ? rexp[4:0] : 5'd0), rmant[9:0]};
    rflags = 5'b00000;
    rflags[FLAG_NX] = nx;
    rflags[FLAG_UF] = tiny & nx;
    if (FTZ && !rmant[10]) begin
      rq              = {sign_q, 15'd0};
      rflags[FLAG_UF] = 1'b1;
      rflags[FLAG_NX] = 1'b1;
    end
    if (rexp >= 6'(EXP_MAX)) begin
      rq              = POS_INF | {sign_q, 15'd0};
      rflags          = 5'b00000;
      rflags[FLAG_OF] = 1'b1;
      rflags[FLAG_NX] = 1'b1;
    end
    // Exact cancellation always yields +0, whatever the operand signs.
    if (nm_q == 14'd0) begin
      rq     = 16'h0000;
      rflags = 5'b00000;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    nm_d    = nm_q;
    nexp_d  = nexp_q;
    q_d     = q_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          a_d  = IN_A;
          b_d  = IN_B;
          op_d = IN_OP;
          if (FAST_SPECIAL && sp_hit) begin
            q_d     = sp_q;
            flags_d = sp_flags;
            state_d = S_DONE;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        sign_d  = big_sign;
        exp_d   = big_exp;
        big_d   = {big_mant, 3'b000};
        small_d = aligned;
        sub_d   = ua.sign ^ ub.sign;
        state_d = S_MAG;
      end
      S_MAG: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[14]) begin
          nm_d   = {sum_q[14:2], sum_q[1] | sum_q[0]};
          nexp_d = {1'b0, exp_q} + 6'd1;
        end else begin
          nm_d   = lz_val;
          nexp_d = lz_exp;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        q_d     = sp_hit ? sp_q     : rq;
        flags_d = sp_hit ? sp_flags : rflags;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    flags_d[FLAG_DZ] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      nm_q    <= '0;
      nexp_q  <= '0;
      q_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      nm_q    <= nm_d;
      nexp_q  <= nexp_d;
      q_q     <= q_d;
      flags_q <= flags_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q != S_IDLE);
  assign Q         = q_q;
  assign FLAGS     = flags_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_half_addsub_seq.sv
// Directed bench for half_addsub_seq: expected results queued at issue,
// popped and compared when OUT_VALID appears.
module tb_half_addsub_seq;
  import fp16_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_OP = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [15:0] IN_A = 16'h0000;
  logic [15:0] IN_B = 16'h0000;
  logic        IN_READY, OUT_VALID, BUSY;
  logic [15:0] Q;
  logic [4:0]  FLAGS;
  state_e      DBG_STATE;

  int tests = 0;
  int fails = 0;
  logic [20:0] exp_q[$];

  half_addsub_seq #(.FAST_SPECIAL(1'b1), .FTZ(1'b0)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .IN_OP     (IN_OP),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .FLAGS     (FLAGS),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, measure edges from accept to OUT_VALID (accept edge
  // counts as 1), optionally stall the consumer for 'hold' cycles, then take it.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic [15:0] eq, input logic [4:0] ef,
                        input int lat, input int hold);
    int          n;
    logic        busy_ok;
    logic        stable_ok;
    logic [20:0] e;
    logic [15:0] q_hold;
    logic [4:0]  f_hold;
    exp_q.push_back({eq, ef});
    check({tag, "_ready"}, IN_READY, 1);
    IN_A = a; IN_B = b; IN_OP = op; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_A = ~a; IN_B = ~b; IN_OP = ~op;
    n = 1;
    busy_ok = 1'b1;
    while (OUT_VALID !== 1'b1 && n < 20) begin
      if (!(BUSY === 1'b1 && IN_READY === 1'b0)) busy_ok = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    if (!(BUSY === 1'b1 && IN_READY === 1'b0)) busy_ok = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy"}, busy_ok, 1);
    e = exp_q.pop_front();
    check({tag, "_q"}, Q, e[20:5]);
    check({tag, "_flags"}, FLAGS, e[4:0]);
    if (hold > 0) begin
      q_hold = Q; f_hold = FLAGS; stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == 3) begin
          IN_VALID = 1'b1; IN_A = 16'h4400; IN_B = 16'h4400; IN_OP = 1'b0;
        end else begin
          IN_VALID = 1'b0;
        end
        @(posedge CLK); #1;
        if (Q !== q_hold || FLAGS !== f_hold || OUT_VALID !== 1'b1 || IN_READY !== 1'b0)
          stable_ok = 1'b0;
      end
      IN_VALID = 1'b0;
      check({tag, "_stall_stable"}, stable_ok, 1);
      check({tag, "_stall_q"}, q_hold, eq);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check({tag, "_taken_valid"}, OUT_VALID, 0);
    check({tag, "_taken_ready"}, IN_READY, 1);
    check({tag, "_q_kept"}, Q, eq);
    if (hold > 0) begin
      repeat (2) begin @(posedge CLK); #1; end
      check({tag, "_no_phantom"}, {OUT_VALID, BUSY}, 2'b00);
    end
  endtask

  initial begin
    int   n;
    int   hold;
    #1;
    check("rst_q", Q, 16'h0000);
    check("rst_flags", FLAGS, 5'b00000);
    check("rst_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_ready", IN_READY, 1);

    run_op("add_1_2",     16'h3C00, 16'h4000, 1'b0, 16'h4200, 5'b00000, 5, 0);
    run_op("cancel",      16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'b00000, 5, 0);
    run_op("sub_subnorm", 16'h0400, 16'h0001, 1'b1, 16'h03FF, 5'b00000, 5, 0);
    run_op("overflow",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b00011, 5, 0);
    run_op("sticky_only", 16'h3C00, 16'h0001, 1'b0, 16'h3C00, 5'b00001, 5, 0);
    run_op("tie_even",    16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'b00001, 5, 0);
    run_op("tie_up",      16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5'b00001, 5, 0);
    run_op("neg_sum",     16'hC000, 16'h3C00, 1'b1, 16'hC200, 5'b00000, 5, 0);
    run_op("opp_cancel",  16'h3C00, 16'hBC00, 1'b0, 16'h0000, 5'b00000, 5, 0);
    run_op("tiny_add",    16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00000, 5, 0);
    run_op("inf_m_inf",   16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'b10000, 1, 0);
    run_op("snan",        16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000, 1, 0);
    run_op("inf_p_fin",   16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 5'b00000, 1, 0);
    run_op("nz_p_nz",     16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b00000, 1, 0);
    run_op("pz_p_nz",     16'h0000, 16'h8000, 1'b0, 16'h0000, 5'b00000, 1, 0);
    run_op("zero_m_x",    16'h0000, 16'h4000, 1'b1, 16'hC000, 5'b00000, 1, 0);

    hold = $urandom_range(10, 14);
    run_op("backpress",   16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'b00000, 5, hold);

    // Abort an operation from NORM with an asynchronous reset.
    IN_A = 16'h3C00; IN_B = 16'h4000; IN_OP = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n = 0;
    while (DBG_STATE != S_NORM && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    check("abort_reach_norm", DBG_STATE, S_NORM);
    #2 RST_N = 1'b0;
    #1;
    check("abort_valid", OUT_VALID, 0);
    check("abort_q", Q, 16'h0000);
    check("abort_flags", FLAGS, 5'b00000);
    check("abort_busy", BUSY, 0);
    @(posedge CLK); #1;
    check("abort_held_valid", OUT_VALID, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("abort_ready", IN_READY, 1);
    run_op("after_reset", 16'h4000, 16'h4000, 1'b0, 16'h4400, 5'b00000, 5, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
